// File: rtl/glitch_free_lut_if.sv
// Serial truth-table configuration channel for glitch_free_lut.
//   cfg_start : one-cycle pulse that begins (or restarts) a table load
//   cfg_valid : cfg_data carries a table bit this cycle
//   cfg_data  : serial table bit, index 0 first
//   cfg_ready : the LUT is accepting table bits
// master = configuration source, slave = the LUT.
interface glitch_free_lut_if;
   logic cfg_start;
   logic cfg_valid;
   logic cfg_data;
   logic cfg_ready;

   modport master (
      output cfg_start,
      output cfg_valid,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_start,
      input  cfg_valid,
      input  cfg_data,
      output cfg_ready
   );
endinterface

// File: rtl/glitch_free_lut.sv
// Glitch-free N-input lookup table.
// The asynchronous inputs i are synchronized, then debounced: a value must
// sit unchanged on the synchronizer output for STABLE+1 cycles before it is
// used to address the table. The output o is a plain flop, so it can never
// glitch. The table can be reloaded at run time over a serial channel; the
// new contents are staged in a shadow register and swapped in atomically.
//   clk     : clock, all state changes on the rising edge
//   nrst    : asynchronous active-low reset
//   i       : N asynchronous function inputs
//   cfg     : serial table-load channel (slave side)
//   o       : registered table[filtered i]
//   o_valid : o reflects the current filtered input under the current table
module glitch_free_lut #(
   parameter int N = 4,
   parameter int STABLE = 2,
   parameter logic [2**N-1:0] INIT = '0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [N-1:0]     i,
   glitch_free_lut_if.slave cfg,
   output logic             o,
   output logic             o_valid
);

   localparam int DEPTH = 2**N;
   localparam int CW = $clog2(STABLE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
   localparam logic [N-1:0]  K_LAST  = N'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [N-1:0]     k_reg, k_next;
   logic [DEPTH-1:0] lut_reg;
   logic [DEPTH-1:0] shadow_reg;
   logic [N-1:0]     s1_reg, s2_reg;
   logic [N-1:0]     p_reg;
   logic [CW-1:0]    cnt_reg;
   logic             o_reg;
   logic             o_valid_reg, o_valid_next;
   logic             cfg_ready_reg;
   logic             accept;
   logic             commit;
   logic             settled;

   assign settled = (cnt_reg == CNT_MAX);

   // Load sequencer: next state, beat index and beat acceptance.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (cfg.cfg_start) begin
               state_next = ST_LOAD;
               k_next     = '0;
            end
         end
         ST_LOAD: begin
            // A start pulse restarts the load and discards any beat offered
            // in the same cycle.
            if (cfg.cfg_start) begin
               k_next = '0;
            end else if (cfg.cfg_valid && cfg_ready_reg) begin
               accept = 1'b1;
               k_next = k_reg + N'(1);
               if (k_reg == K_LAST) begin
                  state_next = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            // The commit always completes; a start seen here goes straight
            // on to a fresh load.
            commit     = 1'b1;
            k_next     = '0;
            state_next = cfg.cfg_start ? ST_LOAD : ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // o_valid drops on the same edge that leaves RUN, so it is already low
   // in the first LOAD cycle.
   always_comb begin
      o_valid_next = (state_reg == ST_RUN) && (state_next == ST_RUN) && settled;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg     <= ST_RUN;
         k_reg         <= '0;
         lut_reg       <= INIT;
         shadow_reg    <= '0;
         cfg_ready_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         cfg_ready_reg <= (state_next == ST_LOAD);
         if (accept) begin
            shadow_reg[k_reg] <= cfg.cfg_data;
         end
         if (commit) begin
            lut_reg <= shadow_reg;
         end
      end
   end

   // Synchronizer and stability filter. The filter keeps running during a
   // load; a commit restarts the count so the new table is only used after
   // a full settle period.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_reg  <= '0;
         s2_reg  <= '0;
         p_reg   <= '0;
         cnt_reg <= '0;
      end else begin
         s1_reg <= i;
         s2_reg <= s1_reg;
         if (s2_reg != p_reg) begin
            p_reg <= s2_reg;
         end
         if (commit || (s2_reg != p_reg)) begin
            cnt_reg <= '0;
         end else if (!settled) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         o_reg       <= 1'b0;
         o_valid_reg <= 1'b0;
      end else begin
         o_valid_reg <= o_valid_next;
         if ((state_reg == ST_RUN) && settled) begin
            o_reg <= lut_reg[p_reg];
         end
      end
   end

   assign o             = o_reg;
   assign o_valid       = o_valid_reg;
   assign cfg.cfg_ready = cfg_ready_reg;

endmodule

// File: tb/tb_glitch_free_lut.sv
// Self-checking bench for glitch_free_lut. Two instances share clock and
// reset: A (N=4, STABLE=2, INIT=16'h8000) and B (N=8, STABLE=1). Expected
// outputs come from a truth-table model (tbl_a / tbl_b) updated on every
// commit, combined with the documented latencies.
module tb_glitch_free_lut;

   localparam logic [15:0]  INIT_A = 16'h8000;
   localparam logic [255:0] INIT_B = {64{4'h5}};

   logic clk = 1'b0;
   logic nrst;
   logic [3:0] i_a;
   logic [7:0] i_b;
   logic o_a, o_valid_a, o_b, o_valid_b;

   glitch_free_lut_if cfg_a();
   glitch_free_lut_if cfg_b();

   glitch_free_lut #(.N(4), .STABLE(2), .INIT(INIT_A)) dut_a (
      .clk     (clk),
      .nrst    (nrst),
      .i       (i_a),
      .cfg     (cfg_a),
      .o       (o_a),
      .o_valid (o_valid_a)
   );

   glitch_free_lut #(.N(8), .STABLE(1), .INIT(INIT_B)) dut_b (
      .clk     (clk),
      .nrst    (nrst),
      .i       (i_b),
      .cfg     (cfg_b),
      .o       (o_b),
      .o_valid (o_valid_b)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errors = 0;
   int cyc = 0;
   logic [15:0]  tbl_a;
   logic [255:0] tbl_b;
   logic [3:0]   cur_a;

   typedef struct {
      int   due;
      logic exp;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive i_a to v and check o follows exactly six edges later.
   task automatic apply_a(input logic [3:0] v);
      logic prev;
      prev = tbl_a[cur_a];
      i_a = v;
      repeat (5) tick();
      check("a_hold5", 32'(o_a), 32'(prev));
      tick();
      check("a_o6", 32'(o_a), 32'(tbl_a[v]));
      check("a_ov6", 32'(o_valid_a), 32'd1);
      cur_a = v;
      $display("[TB] A i=%h o=%b o_valid=%b", v, o_a, o_valid_a);
   endtask

   // Offer beats first..first+count-1 of w with randomly toggling valid.
   task automatic send_beats(input bit sel, input logic [255:0] w, input int first, input int count);
      int idx;
      int budget;
      logic vld;
      logic rdy;
      idx = first;
      budget = 0;
      while (idx < first + count && budget < 4000) begin
         vld = 1'($urandom_range(0, 1));
         if (sel) begin
            rdy = cfg_b.cfg_ready;
            cfg_b.cfg_valid = vld;
            cfg_b.cfg_data  = w[idx];
         end else begin
            rdy = cfg_a.cfg_ready;
            cfg_a.cfg_valid = vld;
            cfg_a.cfg_data  = w[idx];
            check("a_load_ov", 32'(o_valid_a), 32'd0);
         end
         tick();
         if (vld && rdy) idx++;
         budget++;
      end
      cfg_a.cfg_valid = 1'b0;
      cfg_b.cfg_valid = 1'b0;
      check("beat_budget", 32'(idx), 32'(first + count));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0]  w1, w2;
      logic [255:0] wb;
      logic         prev;
      logic         seen;
      logic [7:0]   v;
      int           h;

      nrst = 1'b0;
      i_a = '0;
      i_b = '0;
      cfg_a.cfg_start = 1'b0; cfg_a.cfg_valid = 1'b0; cfg_a.cfg_data = 1'b0;
      cfg_b.cfg_start = 1'b0; cfg_b.cfg_valid = 1'b0; cfg_b.cfg_data = 1'b0;
      tbl_a = INIT_A;
      tbl_b = INIT_B;
      cur_a = '0;

      // ---- reset state and first evaluation after release ----
      repeat (3) tick();
      check("rst_o_a", 32'(o_a), 32'd0);
      check("rst_ov_a", 32'(o_valid_a), 32'd0);
      check("rst_rdy_a", 32'(cfg_a.cfg_ready), 32'd0);
      check("rst_o_b", 32'(o_b), 32'd0);
      nrst = 1'b1;
      tick();
      check("rel1_ov_a", 32'(o_valid_a), 32'd0);
      check("rel1_o_b", 32'(o_b), 32'd0);
      check("rel1_ov_b", 32'(o_valid_b), 32'd0);
      tick();
      check("rel2_o_b", 32'(o_b), 32'(tbl_b[0]));
      check("rel2_ov_b", 32'(o_valid_b), 32'd1);
      check("rel2_ov_a", 32'(o_valid_a), 32'd0);
      tick();
      check("rel3_o_a", 32'(o_a), 32'(tbl_a[0]));
      check("rel3_ov_a", 32'(o_valid_a), 32'd1);
      $display("[TB] reset released, o_a=%b o_b=%b", o_a, o_b);

      // ---- basic latency ----
      apply_a(4'hF);
      apply_a(4'h7);
      apply_a(4'h0);

      // ---- pulse filtering: 2-cycle pulse blocked, 3-cycle pulse passes ----
      i_a = 4'hF;
      repeat (2) tick();
      i_a = 4'h0;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         seen = seen | o_a;
      end
      check("pulse2_blocked", 32'(seen), 32'(tbl_a[0]));
      $display("[TB] A pulse 2 cycles, o seen high=%b", seen);
      i_a = 4'hF;
      repeat (3) tick();
      i_a = 4'h0;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         seen = seen | o_a;
      end
      check("pulse3_pass", 32'(seen), 32'(tbl_a[4'hF]));
      $display("[TB] A pulse 3 cycles, o seen high=%b", seen);
      repeat (4) tick();

      // ---- table load with i=3 held ----
      apply_a(4'h3);
      cfg_a.cfg_start = 1'b1;
      tick();
      cfg_a.cfg_start = 1'b0;
      check("ld_entry_ov", 32'(o_valid_a), 32'd0);
      check("ld_entry_rdy", 32'(cfg_a.cfg_ready), 32'd1);
      send_beats(1'b0, 256'(16'hFFFE), 0, 16);
      check("ld_done_rdy", 32'(cfg_a.cfg_ready), 32'd0);
      check("ld_done_ov", 32'(o_valid_a), 32'd0);
      prev = tbl_a[3];
      tick();                         // COMMIT edge
      tbl_a = 16'hFFFE;
      tick();
      tick();
      check("cm2_o", 32'(o_a), 32'(prev));
      check("cm2_ov", 32'(o_valid_a), 32'd0);
      tick();
      check("cm3_o", 32'(o_a), 32'(tbl_a[3]));
      check("cm3_ov", 32'(o_valid_a), 32'd1);
      $display("[TB] A load FFFE committed, o=%b o_valid=%b", o_a, o_valid_a);

      // ---- restart on the final beat ----
      w2 = 16'($urandom) | 16'h0001;
      w1 = ~w2;
      cfg_a.cfg_start = 1'b1;
      tick();
      cfg_a.cfg_start = 1'b0;
      send_beats(1'b0, 256'(w1), 0, 15);
      cfg_a.cfg_start = 1'b1;
      cfg_a.cfg_valid = 1'b1;
      cfg_a.cfg_data  = w1[15];
      tick();
      cfg_a.cfg_start = 1'b0;
      cfg_a.cfg_valid = 1'b0;
      check("rs_rdy", 32'(cfg_a.cfg_ready), 32'd1);
      send_beats(1'b0, 256'(w2), 0, 15);
      check("rs_rdy15", 32'(cfg_a.cfg_ready), 32'd1);
      send_beats(1'b0, 256'(w2), 15, 1);
      check("rs_rdy16", 32'(cfg_a.cfg_ready), 32'd0);
      tick();                         // COMMIT edge
      tbl_a = w2;
      $display("[TB] A restarted load committed table=%h", w2);
      for (int n = 0; n < 6; n++) apply_a(4'($urandom));
      apply_a(4'h0);                  // w2[0] is 1

      // ---- reset in the middle of a load ----
      cfg_a.cfg_start = 1'b1;
      tick();
      cfg_a.cfg_start = 1'b0;
      send_beats(1'b0, 256'(16'h00FF), 0, 7);
      #2;
      nrst = 1'b0;
      #1;
      check("mid_rst_o", 32'(o_a), 32'd0);
      check("mid_rst_ov", 32'(o_valid_a), 32'd0);
      check("mid_rst_rdy", 32'(cfg_a.cfg_ready), 32'd0);
      tbl_a = INIT_A;
      tbl_b = INIT_B;
      tick();
      nrst = 1'b1;
      repeat (4) tick();
      check("post_rst_o", 32'(o_a), 32'(tbl_a[0]));
      check("post_rst_ov", 32'(o_valid_a), 32'd1);
      $display("[TB] A reset mid-load, table back to INIT");
      apply_a(4'hF);
      apply_a(4'h3);

      // ---- B: random table, random stable inputs, latency 5 ----
      wb = {8{32'h0}};
      for (int n = 0; n < 8; n++) wb[n*32 +: 32] = $urandom;
      cfg_b.cfg_start = 1'b1;
      tick();
      cfg_b.cfg_start = 1'b0;
      send_beats(1'b1, wb, 0, 256);
      check("b_ld_rdy", 32'(cfg_b.cfg_ready), 32'd0);
      tick();                         // COMMIT edge
      tbl_b = wb;
      $display("[TB] B random table committed");
      for (int n = 0; n < 60; n++) begin
         v = 8'($urandom);
         h = $urandom_range(3, 6);
         i_b = v;
         exp_q.push_back('{due: cyc + 5, exp: tbl_b[v]});
         for (int c = 0; c < h; c++) begin
            tick();
            check("b_no_x", 32'($isunknown(o_b)), 32'd0);
            while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               check("b_o", 32'(o_b), 32'(exp_q[0].exp));
               check("b_ov", 32'(o_valid_b), 32'd1);
               $display("[TB] B due=%0d o=%b", cyc, o_b);
               void'(exp_q.pop_front());
            end
         end
      end
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         tick();
         check("b_no_x", 32'($isunknown(o_b)), 32'd0);
         while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("b_o", 32'(o_b), 32'(exp_q[0].exp));
            check("b_ov", 32'(o_valid_b), 32'd1);
            void'(exp_q.pop_front());
         end
      end
      check("b_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/glitch_free_lut.md
GLITCH_FREE_LUT -- requirements
Module: glitch_free_lut

Interface
REQ-001 SHALL have parameter N, default 4: number of function inputs, legal range 1..8.
REQ-002 SHALL have parameter STABLE, default 2: filter depth in cycles, legal range 1..15.
REQ-003 SHALL have parameter INIT, default all-zero, width 2**N: truth table loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i, input, N bits: asynchronous function inputs.
REQ-007 SHALL have port cfg_start, input, 1 bit: single-cycle pulse that begins a table load.
REQ-008 SHALL have port cfg_valid, input, 1 bit: cfg_data carries a valid table bit.
REQ-009 SHALL have port cfg_data, input, 1 bit: serial table bit, index 0 first.
REQ-010 SHALL have port cfg_ready, output, 1 bit: block accepts table bits.
REQ-011 SHALL have port o, output, 1 bit: registered, glitch-free value table[filtered i].
REQ-012 SHALL have port o_valid, output, 1 bit: o reflects the current filtered input under the current table.

Function
REQ-013 SHALL pass i through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 SHALL hold a filtered value p and a counter cnt of width clog2(STABLE+1).
- If s2 != p: p <= s2, cnt <= 0.
- Else: cnt increments, saturating at STABLE.
REQ-015 SHALL register o <= table[p] only in cycles where cnt == STABLE; otherwise o holds its value.
REQ-016 SHALL produce o as a flop output only, with no combinational path from i, table or state to o.
REQ-017 SHALL register o_valid <= (state == RUN) && (cnt == STABLE).
REQ-018 SHALL have a latency of STABLE+4 rising edges from a stable change of i (meeting setup) to the updated o. With STABLE=2 this is 6 edges.
REQ-019 SHALL never propagate to o any s2 pulse of STABLE cycles or fewer; a pulse of STABLE+1 cycles or more SHALL propagate.
REQ-020 SHALL implement an FSM with states RUN, LOAD and COMMIT.
REQ-021 SHALL, in RUN with a cfg_start pulse: go to LOAD, set the bit index k to 0, and leave cfg_ready at 0 that cycle.
REQ-022 SHALL, in LOAD: drive cfg_ready = 1; on cfg_valid && cfg_ready, write shadow[k] <= cfg_data and increment k.
REQ-023 SHALL, in LOAD on acceptance of beat k = 2**N - 1: go to COMMIT with cfg_ready <= 0.
REQ-024 SHALL, in COMMIT (one cycle): copy table <= shadow atomically, force cnt <= 0, and go to RUN.
REQ-025 SHALL, while in LOAD or COMMIT: drive o_valid = 0, hold o, keep evaluation on the old table, and keep the filter running.
REQ-026 SHALL treat cfg_start in LOAD (including the final-beat cycle) as a restart: k <= 0, shadow contents don't-care, and any beat in that cycle discarded.
REQ-027 SHALL let cfg_start in COMMIT complete the commit first, then enter LOAD on the following cycle.
REQ-028 SHALL ignore cfg_valid outside LOAD.
REQ-029 SHALL make the new table effective for the first evaluation after COMMIT: o is re-evaluated STABLE+1 edges after COMMIT, with o_valid rising on the same edge.

Reset
REQ-030 SHALL, on nrst low (immediately, without clk): set state = RUN, table = INIT, shadow = 0, k = 0, s1 = s2 = p = 0, cnt = 0, o = 0, o_valid = 0, cfg_ready = 0.
REQ-031 SHALL abandon a load interrupted by reset, leaving table = INIT.
REQ-032 SHALL resume clocked operation on the first rising edge after nrst deasserts. With i held at 0, o = INIT[0] and o_valid = 1 after edge STABLE+1.

Verification
REQ-033 SHALL cover: N=4, STABLE=2, INIT=16'h8000; i: 0 -> 4'hF held -> o = 1 and o_valid = 1 exactly 6 edges later; i -> 4'h7 -> o = 0 six edges later.
REQ-034 SHALL cover: same config, i = 0, then 4'hF pulsed so s2 holds it for 2 cycles -> o stays 0; pulse of 3 cycles -> o = 1 for at least 1 cycle.
REQ-035 SHALL cover: cfg_start, then 16 beats of 16'hFFFE with cfg_valid toggling randomly and i = 4'h3 held -> o_valid = 0 from LOAD entry; COMMIT; o = 1 and o_valid = 1 three edges after COMMIT.
REQ-036 SHALL cover: cfg_start asserted together with beat 15 -> load restarts at k = 0, table unchanged, cfg_ready still 1; a full 16 further beats are needed to commit.
REQ-037 SHALL cover: nrst pulsed low mid-LOAD after 7 beats -> o = 0, o_valid = 0 and cfg_ready = 0 immediately; table = INIT afterwards.
REQ-038 SHALL cover: N=8, STABLE=1 with random table and random i stable for 3 or more cycles -> o matches the reference model table[i] at latency 5 edges, with no X on o at any time.
